// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types and constants for the pipeline hazard controller.
//   sb_entry_t : one scoreboard slot {valid, dst, wr, load}
//   FWD_RF     : forwarding code meaning "take the operand from the register file"
//   CNT_W      : width of the saturating stall counter
package pipe_pkg;

    // Widest register address the scoreboard can hold; narrower AW values are zero-extended.
    localparam int unsigned SB_DST_W = 16;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Code 0 selects the register file; code k selects the result held in stage k-1.
    localparam int unsigned FWD_RF = 0;

    typedef struct packed {
        logic                valid;
        logic [SB_DST_W-1:0] dst;
        logic                wr;
        logic                load;
    } sb_entry_t;

endpackage

// File: rtl/hz_match.sv
// hz_match: finds the youngest scoreboard entry that writes a given source register.
//   i_use     : the source register is actually read
//   i_src     : source register address
//   i_sb      : scoreboard, entry k = instruction now in post-decode stage k
//   o_hit     : some in-flight instruction writes i_src
//   o_k       : stage index of the youngest such instruction
//   o_is_load : that instruction is a load
module hz_match
    import pipe_pkg::*;
#(
    parameter int unsigned AW   = 5,
    parameter int unsigned NSTG = 3,
    parameter int unsigned KW   = 2
) (
    input  logic          i_use,
    input  logic [AW-1:0] i_src,
    input  sb_entry_t     i_sb [NSTG],
    output logic          o_hit,
    output logic [KW-1:0] o_k,
    output logic          o_is_load
);

    logic w_src_zero;
    assign w_src_zero = (i_src == '0);

    always_comb begin
        o_hit     = 1'b0;
        o_k       = '0;
        o_is_load = 1'b0;
        // Walk from oldest to youngest so the lowest matching stage wins.
        for (int k = int'(NSTG) - 1; k >= 0; k--) begin
            if (i_use && !w_src_zero && i_sb[k].valid && i_sb[k].wr &&
                (i_sb[k].dst == SB_DST_W'(i_src))) begin
                o_hit     = 1'b1;
                o_k       = KW'(k);
                o_is_load = i_sb[k].load;
            end
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard detection, operand forwarding select and branch flush
// for an in-order pipeline with NSTG tracked post-decode stages.
//   clk_PHC, rst_PHC        : clock, synchronous active-high reset
//   id_*                    : instruction in decode (sources, destination, RegWrite, MemRead)
//   br_taken                : taken branch resolved in stage BR_STAGE this cycle
//   stall                   : hold PC and IF/ID, send a bubble into EX
//   flush_ifid              : discard the IF/ID instruction
//   fwd_a, fwd_b            : EX operand source, registered as the instruction enters EX
//   stall_cnt               : saturating count of stall cycles
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned AW       = 5,
    parameter int unsigned NSTG     = 3,
    parameter int unsigned FWD_EN   = 1,
    parameter int unsigned LD_LAT   = 1,
    parameter int unsigned BR_STAGE = 1,
    localparam int unsigned CW      = $clog2(NSTG + 1)
) (
    input  logic             clk_PHC,
    input  logic             rst_PHC,
    input  logic             id_valid,
    input  logic [AW-1:0]    id_rs,
    input  logic [AW-1:0]    id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic [AW-1:0]    id_dst,
    input  logic             id_wr,
    input  logic             id_load,
    input  logic             br_taken,
    output logic             stall,
    output logic             flush_ifid,
    output logic [CW-1:0]    fwd_a,
    output logic [CW-1:0]    fwd_b,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CW-1:0] LD_LAT_C = CW'(LD_LAT);
    localparam logic [CW-1:0] FWD_RF_C = CW'(FWD_RF);

    sb_entry_t        r_sb [NSTG];
    logic [CW-1:0]    r_fwd_a;
    logic [CW-1:0]    r_fwd_b;
    logic [CNT_W-1:0] r_stall_cnt;

    logic          w_hit_a, w_hit_b;
    logic [CW-1:0] w_k_a, w_k_b;
    logic          w_ld_a, w_ld_b;
    logic          w_haz_a, w_haz_b;
    logic          w_stall, w_move;
    logic [CW-1:0] w_code_a, w_code_b;
    sb_entry_t     w_id_entry;

    hz_match #(
        .AW   (AW),
        .NSTG (NSTG),
        .KW   (CW)
    ) u_match_a (
        .i_use     (id_use_rs),
        .i_src     (id_rs),
        .i_sb      (r_sb),
        .o_hit     (w_hit_a),
        .o_k       (w_k_a),
        .o_is_load (w_ld_a)
    );

    hz_match #(
        .AW   (AW),
        .NSTG (NSTG),
        .KW   (CW)
    ) u_match_b (
        .i_use     (id_use_rt),
        .i_src     (id_rt),
        .i_sb      (r_sb),
        .o_hit     (w_hit_b),
        .o_k       (w_k_b),
        .o_is_load (w_ld_b)
    );

    // Without forwarding every match blocks; with it only a load still inside its
    // latency window does.
    assign w_haz_a = w_hit_a && ((FWD_EN == 0) || (w_ld_a && (w_k_a < LD_LAT_C)));
    assign w_haz_b = w_hit_b && ((FWD_EN == 0) || (w_ld_b && (w_k_b < LD_LAT_C)));

    // A taken branch kills the decode instruction, so it must never be held.
    assign w_stall = !rst_PHC && id_valid && !br_taken && (w_haz_a || w_haz_b);
    assign w_move  = id_valid && !w_stall && !br_taken;

    assign w_code_a = ((FWD_EN != 0) && w_hit_a) ? (w_k_a + CW'(1)) : FWD_RF_C;
    assign w_code_b = ((FWD_EN != 0) && w_hit_b) ? (w_k_b + CW'(1)) : FWD_RF_C;

    always_comb begin
        w_id_entry       = '0;
        w_id_entry.valid = 1'b1;
        w_id_entry.dst   = SB_DST_W'(id_dst);
        w_id_entry.wr    = id_wr;
        w_id_entry.load  = id_load;
    end

    always_ff @(posedge clk_PHC) begin
        if (rst_PHC) begin
            for (int k = 0; k < int'(NSTG); k++) begin
                r_sb[k] <= '0;
            end
            r_fwd_a     <= '0;
            r_fwd_b     <= '0;
            r_stall_cnt <= '0;
        end else begin
            // Entries younger than the branch are squashed as they shift.
            for (int k = int'(NSTG) - 1; k > 0; k--) begin
                r_sb[k] <= (br_taken && ((k - 1) < int'(BR_STAGE))) ? '0 : r_sb[k-1];
            end
            r_sb[0] <= w_move ? w_id_entry : '0;
            r_fwd_a <= w_move ? w_code_a : FWD_RF_C;
            r_fwd_b <= w_move ? w_code_b : FWD_RF_C;
            if (w_stall && (r_stall_cnt != CNT_MAX)) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end

    assign stall      = w_stall;
    assign flush_ifid = !rst_PHC && br_taken;
    assign fwd_a      = r_fwd_a;
    assign fwd_b      = r_fwd_b;
    assign stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl. Two instances share one stimulus stream: u_def (defaults)
// and u_nf (FWD_EN=0). A model tracks each issued instruction by the cycle it entered EX;
// its stage is its age, and it is checked against both instances every cycle. A third
// instance u_sat (NSTG=6, FWD_EN=0) is driven with a permanent load-use chain to push
// stall_cnt into saturation.
module tb_pipe_hazard_ctrl;

    localparam int M_NSTG  = 3;
    localparam int M_LDLAT = 1;
    localparam int M_BRST  = 1;
    localparam int NREC    = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    // shared stimulus for u_def / u_nf
    logic       rst, iv, urs, urt, wr, ld, br;
    logic [4:0] rs, rt, dst;

    logic       d_stall, d_flush, n_stall, n_flush;
    logic [1:0] d_fa, d_fb, n_fa, n_fb;
    logic [15:0] d_cnt, n_cnt;

    // stimulus and outputs for u_sat
    logic       s_rst, s_iv, s_urs, s_wr, s_ld;
    logic [4:0] s_rs, s_dst;
    logic       s_stall, s_flush;
    logic [2:0] s_fa, s_fb;
    logic [15:0] s_cnt;

    pipe_hazard_ctrl u_def (
        .clk_PHC (clk), .rst_PHC (rst), .id_valid (iv),
        .id_rs (rs), .id_rt (rt), .id_use_rs (urs), .id_use_rt (urt),
        .id_dst (dst), .id_wr (wr), .id_load (ld), .br_taken (br),
        .stall (d_stall), .flush_ifid (d_flush), .fwd_a (d_fa), .fwd_b (d_fb),
        .stall_cnt (d_cnt)
    );

    pipe_hazard_ctrl #(.FWD_EN (0)) u_nf (
        .clk_PHC (clk), .rst_PHC (rst), .id_valid (iv),
        .id_rs (rs), .id_rt (rt), .id_use_rs (urs), .id_use_rt (urt),
        .id_dst (dst), .id_wr (wr), .id_load (ld), .br_taken (br),
        .stall (n_stall), .flush_ifid (n_flush), .fwd_a (n_fa), .fwd_b (n_fb),
        .stall_cnt (n_cnt)
    );

    pipe_hazard_ctrl #(.NSTG (6), .FWD_EN (0)) u_sat (
        .clk_PHC (clk), .rst_PHC (s_rst), .id_valid (s_iv),
        .id_rs (s_rs), .id_rt (5'd0), .id_use_rs (s_urs), .id_use_rt (1'b0),
        .id_dst (s_dst), .id_wr (s_wr), .id_load (s_ld), .br_taken (1'b0),
        .stall (s_stall), .flush_ifid (s_flush), .fwd_a (s_fa), .fwd_b (s_fb),
        .stall_cnt (s_cnt)
    );

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- model: instruction records stamped with issue cycle -------------
    int cyc = 0;
    int rec_iss  [2][NREC];
    int rec_dst  [2][NREC];
    bit rec_wr   [2][NREC];
    bit rec_ld   [2][NREC];
    bit rec_dead [2][NREC];
    int rec_wp   [2];
    int m_fa [2];
    int m_fb [2];
    int m_cnt[2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < NREC; j++) rec_dead[i][j] = 1'b1;
            rec_wp[i] = 0; m_fa[i] = 0; m_fb[i] = 0; m_cnt[i] = 0;
        end
    end

    // Stage currently occupied by record j (0 = EX).
    function automatic int age(input int i, input int j);
        return cyc - rec_iss[i][j] - 1;
    endfunction

    function automatic int find(input int i, input bit use_s, input int src);
        int best = -1;
        if (!use_s || src == 0) return -1;
        for (int j = 0; j < NREC; j++) begin
            if (!rec_dead[i][j] && rec_wr[i][j] && rec_dst[i][j] == src &&
                age(i, j) >= 0 && age(i, j) < M_NSTG) begin
                if (best < 0 || age(i, j) < age(i, best)) best = j;
            end
        end
        return best;
    endfunction

    // Instance 0 forwards, instance 1 waits for retirement.
    function automatic bit blocks(input int i, input int j);
        if (j < 0) return 1'b0;
        if (i == 1) return 1'b1;
        return rec_ld[i][j] && (age(i, j) < M_LDLAT);
    endfunction

    function automatic int code(input int i, input int j);
        if (i == 1 || j < 0) return 0;
        return age(i, j) + 1;
    endfunction

    function automatic bit exp_stall(input int i);
        if (rst || !iv || br) return 1'b0;
        return blocks(i, find(i, urs, int'(rs))) || blocks(i, find(i, urt, int'(rt)));
    endfunction

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            bit st;
            int ja, jb;
            st = exp_stall(i);
            ja = find(i, urs, int'(rs));
            jb = find(i, urt, int'(rt));
            if (rst) begin
                for (int j = 0; j < NREC; j++) rec_dead[i][j] = 1'b1;
                m_fa[i] = 0; m_fb[i] = 0; m_cnt[i] = 0;
            end else begin
                if (st && m_cnt[i] < 65535) m_cnt[i]++;
                if (br) begin
                    for (int j = 0; j < NREC; j++)
                        if (!rec_dead[i][j] && age(i, j) < M_BRST) rec_dead[i][j] = 1'b1;
                end
                if (iv && !st && !br) begin
                    m_fa[i] = code(i, ja);
                    m_fb[i] = code(i, jb);
                    rec_iss [i][rec_wp[i]] = cyc;
                    rec_dst [i][rec_wp[i]] = int'(dst);
                    rec_wr  [i][rec_wp[i]] = wr;
                    rec_ld  [i][rec_wp[i]] = ld;
                    rec_dead[i][rec_wp[i]] = 1'b0;
                    rec_wp[i] = (rec_wp[i] + 1) % NREC;
                end else begin
                    m_fa[i] = 0;
                    m_fb[i] = 0;
                end
            end
        end
        cyc++;
    end

    always @(negedge clk) begin
        chk("def_stall", int'(d_stall), int'(exp_stall(0)));
        chk("def_flush", int'(d_flush), int'(!rst && br));
        chk("def_fwd_a", int'(d_fa), m_fa[0]);
        chk("def_fwd_b", int'(d_fb), m_fb[0]);
        chk("def_cnt",   int'(d_cnt), m_cnt[0]);
        chk("nf_stall",  int'(n_stall), int'(exp_stall(1)));
        chk("nf_flush",  int'(n_flush), int'(!rst && br));
        chk("nf_fwd_a",  int'(n_fa), m_fa[1]);
        chk("nf_fwd_b",  int'(n_fb), m_fb[1]);
        chk("nf_cnt",    int'(n_cnt), m_cnt[1]);
    end

    // ---------------- stimulus helpers ----------------
    task automatic put(input bit v, input int d, input int a, input int b,
                       input bit ua, input bit ub, input bit w, input bit l, input bit bt);
        iv = v; dst = 5'(d); rs = 5'(a); rt = 5'(b);
        urs = ua; urt = ub; wr = w; ld = l; br = bt;
    endtask

    task automatic bubble();
        put(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic drain();
        bubble();
        repeat (3) tick();
    endtask

    initial begin
        rst = 1'b1;
        bubble();
        s_rst = 1'b1; s_iv = 1'b0; s_urs = 1'b0; s_wr = 1'b0; s_ld = 1'b0;
        s_rs = 5'd0; s_dst = 5'd0;
        fork
            begin : main_seq
                // reset holds stall/flush low even with a branch and a valid instruction
                put(1'b1, 5, 5, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
                settle();
                chk("rst_stall", int'(d_stall), 0);
                chk("rst_flush", int'(d_flush), 0);
                tick(); tick();
                rst = 1'b0;
                bubble();
                settle();
                chk("rst_fwd_a", int'(d_fa), 0);
                chk("rst_cnt", int'(d_cnt), 0);
                tick();

                // add r3 ; sub r4,r3,r1 -> forward from EX
                put(1'b1, 3, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
                put(1'b1, 4, 3, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); settle();
                chk("alu_nostall", int'(d_stall), 0);
                tick();
                bubble(); settle();
                chk("alu_fwd_a", int'(d_fa), 1);
                chk("alu_fwd_b", int'(d_fb), 0);
                chk("model_pin_alu", m_fa[0], 1);
                drain();

                // lw r5 ; add r6,r5,r5 -> one stall then forward from MEM
                put(1'b1, 5, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
                put(1'b1, 6, 5, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); settle();
                chk("ld_stall1", int'(d_stall), 1);
                tick(); settle();
                chk("ld_stall2", int'(d_stall), 0);
                tick();
                bubble(); settle();
                chk("ld_fwd_a", int'(d_fa), 2);
                chk("ld_fwd_b", int'(d_fb), 2);
                chk("ld_cnt", int'(d_cnt), 1);
                chk("model_pin_ld", m_fb[0], 2);
                drain();

                // writes to r0 never match
                put(1'b1, 0, 1, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); tick();
                put(1'b1, 7, 0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); settle();
                chk("r0_stall", int'(d_stall), 0);
                tick();
                bubble(); settle();
                chk("r0_fwd_a", int'(d_fa), 0);
                chk("r0_fwd_b", int'(d_fb), 0);
                drain();

                // branch in the same cycle as a load-use stall
                put(1'b1, 5, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
                put(1'b1, 6, 5, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); settle();
                chk("br_stall", int'(d_stall), 0);
                chk("br_flush", int'(d_flush), 1);
                tick();
                put(1'b1, 6, 5, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); settle();
                chk("br_fwd_a", int'(d_fa), 0);
                chk("br_after_stall", int'(d_stall), 0);
                chk("br_after_flush", int'(d_flush), 0);
                tick();
                bubble(); settle();
                chk("br_squashed_fwd", int'(d_fa), 0);
                drain();

                // no forwarding: add r2 ; and r8,r2,r2 waits three cycles
                put(1'b1, 2, 1, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
                put(1'b1, 8, 2, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                for (int c = 0; c < 3; c++) begin
                    settle();
                    chk("nf_hold", int'(n_stall), 1);
                    tick();
                end
                settle();
                chk("nf_release", int'(n_stall), 0);
                tick();
                bubble(); settle();
                chk("nf_fwd_a", int'(n_fa), 0);
                chk("nf_fwd_b", int'(n_fb), 0);
                drain();

                // hazard pattern with id_valid low must not stall
                put(1'b1, 5, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
                put(1'b0, 6, 5, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0); settle();
                chk("novalid_stall", int'(d_stall), 0);
                tick();
                drain();

                // two writers of r3: the younger one (EX) wins
                put(1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
                put(1'b1, 3, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
                put(1'b1, 9, 3, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
                bubble(); settle();
                chk("young_fwd_a", int'(d_fa), 1);
                drain();

                // writer in WB -> bypass code NSTG
                put(1'b1, 4, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0); tick();
                bubble(); tick(); tick();
                put(1'b1, 9, 4, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0); tick();
                bubble(); settle();
                chk("wb_fwd_a", int'(d_fa), 3);
                drain();

                // reset during a pending stall: nothing from that cycle survives
                put(1'b1, 5, 0, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0); tick();
                put(1'b1, 6, 5, 5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
                rst = 1'b1; settle();
                chk("rst_mid_stall", int'(d_stall), 0);
                tick();
                rst = 1'b0; settle();
                chk("post_rst_stall", int'(d_stall), 0);
                chk("post_rst_cnt", int'(d_cnt), 0);
                tick();
                drain();
            end
            begin : sat_seq
                tick();
                s_rst = 1'b0;
                s_iv = 1'b1; s_rs = 5'd5; s_urs = 1'b1; s_dst = 5'd5; s_wr = 1'b1; s_ld = 1'b1;
                // six stall cycles in every seven -> more than 65535 stalls
                repeat (78000) @(posedge clk);
                #1;
                chk("sat_cnt", int'(s_cnt), 65535);
                repeat (3) @(posedge clk);
                #1;
                chk("sat_nowrap", int'(s_cnt), 65535);
                s_rst = 1'b1; settle();
                chk("sat_rst_stall", int'(s_stall), 0);
                tick();
                s_rst = 1'b0; s_wr = 1'b0; s_ld = 1'b0; settle();
                chk("sat_cnt_clr", int'(s_cnt), 0);
                chk("sat_sb_empty", int'(s_stall), 0);
                chk("sat_fwd_a", int'(s_fa), 0);
                tick();
            end
        join
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
